// File: rtl/key_debounce_multi_pkg.sv
// Shared types for the multi-key debouncer: per-channel FSM state and synchroniser depth.
package key_pkg;
  typedef enum logic [1:0] {KS_RELEASED, KS_PRESSED, KS_LONG} key_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-flop synchroniser, polarity fold, debounce/long-press FSM
// and registered level / press / release / long pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 750000,
  parameter int LONG_CYC     = 0,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int DW = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = (LONG_CYC < 1) ? 1 : $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DTERM = DW'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
  localparam logic [HW-1:0] HTERM = HW'((LONG_CYC > 0) ? LONG_CYC - 1 : 0);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;
  key_state_t             state, state_nx;
  logic [DW-1:0]          cnt, cnt_nx;
  logic [HW-1:0]          hcnt, hcnt_nx;
  logic                   level_nx, press_nx, release_nx, long_nx;

  // Sync flops come out of reset at the idle pin level so no false press is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{IDLE_PIN}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
  end

  assign p = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= KS_RELEASED;
      cnt         <= '0;
      hcnt        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      hcnt        <= hcnt_nx;
      key_level   <= level_nx;
      key_press   <= press_nx;
      key_release <= release_nx;
      key_long    <= long_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hcnt_nx  = hcnt;
    unique case (state)
      KS_RELEASED: begin
        if (!p)               cnt_nx = '0;
        else if (cnt == DTERM) begin
          state_nx = KS_PRESSED;
          cnt_nx   = '0;
          hcnt_nx  = '0;
        end else              cnt_nx = cnt + 1'b1;
      end
      default: begin
        if (p)                cnt_nx = '0;
        else if (cnt == DTERM) begin
          state_nx = KS_RELEASED;
          cnt_nx   = '0;
        end else              cnt_nx = cnt + 1'b1;
        // Hold timer runs only while PRESSED; a same-cycle release takes priority.
        if (LONG_CYC != 0 && state == KS_PRESSED && state_nx == KS_PRESSED) begin
          if (hcnt == HTERM) state_nx = KS_LONG;
          else               hcnt_nx  = hcnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    level_nx   = (state_nx != KS_RELEASED);
    press_nx   = (state == KS_RELEASED) && (state_nx == KS_PRESSED);
    release_nx = (state != KS_RELEASED) && (state_nx == KS_RELEASED);
    long_nx    = (state == KS_PRESSED)  && (state_nx == KS_LONG);
  end
endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: one independent key_debounce_ch per key pin.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 750000,
  parameter int LONG_CYC     = 0,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end
endmodule
